fetch_sequencer: RTL and testbench
==================================

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter ADDR_W, default 8, SHALL set the program-address width (matches the program counter SIZE).
REQ-002 Parameter DATA_W, default 16, SHALL set the instruction width.
REQ-003 Parameter TIMEOUT, default 15, SHALL set the ack-wait limit in cycles; it is used only under FETCH_TIMEOUT_EN.
REQ-004 clk  in  1  clock; all state SHALL change on the rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 pc  in  ADDR_W  current program-counter value.
REQ-007 incr  out  1  advance strobe to the program counter, which increments on a 0->1 edge.
REQ-008 mem_rd  out  1  ROM read request.
REQ-009 mem_addr  out  ADDR_W  ROM read address.
REQ-010 mem_data  in  DATA_W  ROM read data, valid when mem_ack=1.
REQ-011 mem_ack  in  1  ROM read complete, with a latency of 1 or more cycles after mem_rd.
REQ-012 instr  out  DATA_W  fetched instruction.
REQ-013 instr_valid  out  1  instr is valid for the downstream decoder.
REQ-014 instr_ready  in  1  the decoder accepts instr.
REQ-015 halt  in  1  stop fetching after the current instruction.
REQ-016 fetch_err  out  1  sticky ack-timeout flag; it exists only under FETCH_TIMEOUT_EN.

Function
REQ-017 The FSM SHALL have the states IDLE, REQ, WAIT, HOLD, STEP and SETTLE.
REQ-018 IDLE SHALL go to REQ when halt=0 and otherwise stay in IDLE.
REQ-019 REQ SHALL drive mem_rd=1 and mem_addr=pc for exactly one cycle, latch pc into an internal addr register, then go to WAIT.
REQ-020 WAIT SHALL drive mem_addr=addr and mem_rd=0; on mem_ack=1 it SHALL capture mem_data into instr and go to HOLD.
REQ-021 HOLD SHALL drive instr_valid=1; on instr_valid&instr_ready it SHALL go to STEP; instr SHALL stay stable while instr_valid=1 and ready is low.
REQ-022 STEP SHALL drive incr=1 for exactly one cycle and instr_valid=0.
REQ-023 SETTLE SHALL drive incr=0 for one cycle, which guarantees the PC sees an edge on every instruction; it SHALL then go to IDLE if halt=1, else to REQ.
REQ-024 Minimum per-instruction cost SHALL be 5 cycles with a 1-cycle ack and instr_ready held high.
REQ-025 mem_ack outside WAIT SHALL be ignored.
REQ-026 halt SHALL only be sampled in IDLE and SETTLE; an in-flight fetch SHALL complete and be handed off.
REQ-027 PC wrap-around (all-ones -> 0) SHALL need no special handling; addr is a plain copy of pc.
REQ-028 incr SHALL never be high for two consecutive cycles.
REQ-029 Outputs SHALL be registered; instr_valid=1 only in HOLD, incr=1 only in STEP, mem_rd=1 only in REQ.

Reset
REQ-030 While reset=1, the FSM SHALL be in IDLE with incr=0, mem_rd=0, mem_addr=0, instr=0, instr_valid=0 and fetch_err=0.
REQ-031 Reset mid-fetch SHALL abandon the transaction immediately; a late mem_ack after release SHALL be ignored.
REQ-032 After release, the first mem_rd SHALL occur no earlier than the second rising edge, leaving one cycle in IDLE.

Configuration
REQ-033 With FETCH_TIMEOUT_EN defined, a wait counter SHALL count WAIT cycles; when it reaches TIMEOUT without mem_ack, the block SHALL set fetch_err=1 (sticky until reset) and go to IDLE, and IDLE SHALL not leave while fetch_err=1.
REQ-034 Without FETCH_TIMEOUT_EN, WAIT SHALL wait indefinitely, the fetch_err port SHALL be absent, and no counter logic SHALL be synthesized.

Verification
REQ-035 Reset, then pc=0x00, ack 1 cycle later with data 0xA5A5 and ready=1 -> mem_rd on cycle 2, instr=0xA5A5 with valid for 1 cycle, one incr pulse, next mem_rd with pc=0x01.
REQ-036 Ready held low 10 cycles in HOLD -> instr and instr_valid stay stable, incr=0 throughout, one incr after ready rises.
REQ-037 pc=0xFF wrapping to 0x00 -> next request at mem_addr=0x00 with no extra cycles.
REQ-038 halt=1 asserted during WAIT -> instruction still delivered, one incr, then stays IDLE with mem_rd=0 until halt=0.
REQ-039 reset pulsed during WAIT, mem_ack arrives 2 cycles after release -> ack ignored, instr=0, instr_valid=0, a fresh REQ follows.
REQ-040 FETCH_TIMEOUT_EN with TIMEOUT=15 and no ack -> fetch_err=1 after 15 WAIT cycles, FSM held in IDLE, no incr.

Source files
------------

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fetch_sequencer
// Brief    : Instruction fetch FSM between program counter, ROM and decoder.
//            Optional ack timeout with sticky fetch_err under FETCH_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_sequencer #(
   parameter int ADDR_W  = 8,
   parameter int DATA_W  = 16,
   parameter int TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] pc,
   output logic              incr,
   output logic              mem_rd,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_data,
   input  logic              mem_ack,
   output logic [DATA_W-1:0] instr,
   output logic              instr_valid,
   input  logic              instr_ready,
`ifdef FETCH_TIMEOUT_EN
   output logic              fetch_err,
`endif
   input  logic              halt
);

   localparam logic [2:0] c_IDLE   = 3'd0;
   localparam logic [2:0] c_REQ    = 3'd1;
   localparam logic [2:0] c_WAIT   = 3'd2;
   localparam logic [2:0] c_HOLD   = 3'd3;
   localparam logic [2:0] c_STEP   = 3'd4;
   localparam logic [2:0] c_SETTLE = 3'd5;

   logic [2:0] r_state;
   logic [2:0] w_next_state;
   logic       w_blocked;
   logic       w_timeout;

`ifdef FETCH_TIMEOUT_EN
   localparam int c_CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
   localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);

   logic [c_CNT_W-1:0] r_wait_cnt;

   assign w_blocked = fetch_err;
   assign w_timeout = (r_state == c_WAIT) && !mem_ack && (r_wait_cnt == c_CNT_LAST);

   // Counter restarts on every entry to WAIT; fetch_err only clears on reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wait_cnt <= '0;
         fetch_err  <= 1'b0;
      end else begin
         if (r_state == c_WAIT) begin
            r_wait_cnt <= r_wait_cnt + c_CNT_W'(1);
         end else begin
            r_wait_cnt <= '0;
         end
         if (w_timeout) begin
            fetch_err <= 1'b1;
         end
      end
   end
`else
   assign w_blocked = 1'b0;
   assign w_timeout = 1'b0;

   if (TIMEOUT > 0) begin : g_no_timeout
   end
`endif

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         c_IDLE: begin
            if (!halt && !w_blocked) begin
               w_next_state = c_REQ;
            end
         end
         c_REQ: w_next_state = c_WAIT;
         c_WAIT: begin
            if (mem_ack) begin
               w_next_state = c_HOLD;
            end else if (w_timeout) begin
               w_next_state = c_IDLE;
            end
         end
         c_HOLD: begin
            if (instr_ready) begin
               w_next_state = c_STEP;
            end
         end
         c_STEP:   w_next_state = c_SETTLE;
         c_SETTLE: w_next_state = halt ? c_IDLE : c_REQ;
         default:  w_next_state = c_IDLE;
      endcase
   end

   // Outputs are decoded from the next state so they are registered yet
   // aligned with the state they belong to; mem_addr doubles as the addr latch.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= c_IDLE;
         incr        <= 1'b0;
         mem_rd      <= 1'b0;
         mem_addr    <= '0;
         instr       <= '0;
         instr_valid <= 1'b0;
      end else begin
         r_state     <= w_next_state;
         mem_rd      <= (w_next_state == c_REQ);
         incr        <= (w_next_state == c_STEP);
         instr_valid <= (w_next_state == c_HOLD);
         if (w_next_state == c_REQ) begin
            mem_addr <= pc;
         end
         if ((r_state == c_WAIT) && mem_ack) begin
            instr <= mem_data;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// Scoreboard bench for fetch_sequencer: the bench acts as program counter and
// ROM; expected instructions are rom[pc] for successive pc values.
module tb_fetch_sequencer;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [7:0]  pc;
   logic        incr;
   logic        mem_rd;
   logic [7:0]  mem_addr;
   logic [15:0] mem_data;
   logic        mem_ack;
   logic [15:0] instr;
   logic        instr_valid;
   logic        instr_ready = 1'b1;
   logic        halt = 1'b0;
`ifdef FETCH_TIMEOUT_EN
   logic        fetch_err;
`endif

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   int n_incr = 0;
   int n_valid = 0;
   int n_hs = 0;

   logic [15:0] rom [256];
   logic [15:0] exp_q [$];

   logic        pc_load = 1'b0;
   logic [7:0]  pc_load_val = 8'h00;
   logic        incr_q = 1'b0;

   logic        auto_mem = 1'b0;
   int          lat_max = 1;
   int          stray_pct = 0;
   logic        a_ack = 1'b0;
   logic [15:0] a_data = 16'h0;
   logic        man_ack = 1'b0;
   logic [15:0] man_data = 16'h0;

   assign mem_ack  = auto_mem ? a_ack  : man_ack;
   assign mem_data = auto_mem ? a_data : man_data;

   fetch_sequencer #(.ADDR_W(8), .DATA_W(16), .TIMEOUT(15)) dut (
      .clk         (clk),
      .reset       (reset),
      .pc          (pc),
      .incr        (incr),
      .mem_rd      (mem_rd),
      .mem_addr    (mem_addr),
      .mem_data    (mem_data),
      .mem_ack     (mem_ack),
      .instr       (instr),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
`ifdef FETCH_TIMEOUT_EN
      .fetch_err   (fetch_err),
`endif
      .halt        (halt)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Program counter model: increments on a rising incr, and feeds the scoreboard.
   always @(posedge clk) begin
      logic [7:0] nxt;
      cyc++;
      incr_q <= incr;
      nxt = pc + 8'd1;
      if (pc_load) begin
         pc <= pc_load_val;
         exp_q.delete();
         exp_q.push_back(rom[pc_load_val]);
      end else if (incr && !incr_q) begin
         pc <= nxt;
         exp_q.push_back(rom[nxt]);
      end
   end

   // ROM responder with random latency and stray acks outside a pending read.
   initial begin
      int pend;
      logic [7:0] pa;
      pend = 0;
      pa = 8'h00;
      forever begin
         @(negedge clk);
         if (reset || !auto_mem) begin
            pend  = 0;
            a_ack = 1'b0;
         end else begin
            a_ack  = 1'b0;
            a_data = 16'($urandom);
            if (pend > 0) begin
               pend--;
               if (pend == 0) begin
                  a_ack  = 1'b1;
                  a_data = rom[pa];
               end
            end else if (mem_rd) begin
               pa   = mem_addr;
               pend = int'($urandom_range(lat_max, 1));
            end else if (int'($urandom_range(99, 0)) < stray_pct) begin
               a_ack = 1'b1;
            end
         end
      end
   end

   // Monitor: handshake scoreboard plus protocol properties.
   initial begin
      logic pv, pr, pi;
      logic [15:0] pinstr;
      int hs, n;
      pv = 1'b0; pr = 1'b0; pi = 1'b0; pinstr = 16'h0; hs = 0;
      forever begin
         @(negedge clk);
         #1;
         if (reset) begin
            pv = 1'b0; pi = 1'b0; hs = 0;
            continue;
         end
         if (pv && !pr) begin
            check("hold_valid", 32'(instr_valid), 32'd1);
            check("hold_stable", 32'(instr), 32'(pinstr));
         end
         if (instr_valid) n_valid++;
         if (instr_valid && instr_ready) begin
            if (exp_q.size() == 0) check("instr_unexpected", 32'd1, 32'd0);
            else check("instr", 32'(instr), 32'(exp_q.pop_front()));
            hs++;
            n_hs++;
         end
         if (incr) begin
            n_incr++;
            check("incr_once_per_handoff", 32'(hs), 32'd1);
            check("incr_not_back_to_back", 32'(pi), 32'd0);
            hs = 0;
         end
         if (mem_rd) check("req_addr", 32'(mem_addr), 32'(pc));
         n = int'(mem_rd) + int'(incr) + int'(instr_valid);
         if (n > 0) check("outputs_exclusive", 32'(n), 32'd1);
         pv = instr_valid; pr = instr_ready; pi = incr; pinstr = instr;
      end
   end

   task automatic do_reset(input logic [7:0] start);
      @(negedge clk);
      reset = 1'b1;
      pc_load = 1'b1;
      pc_load_val = start;
      @(negedge clk);
      @(negedge clk);
      check("rst_incr", 32'(incr), 32'd0);
      check("rst_mem_rd", 32'(mem_rd), 32'd0);
      check("rst_mem_addr", 32'(mem_addr), 32'd0);
      check("rst_instr", 32'(instr), 32'd0);
      check("rst_instr_valid", 32'(instr_valid), 32'd0);
`ifdef FETCH_TIMEOUT_EN
      check("rst_fetch_err", 32'(fetch_err), 32'd0);
`endif
      @(posedge clk);
      #1;
      reset = 1'b0;
      pc_load = 1'b0;
   endtask

   task automatic wait_rd(output int c, input int budget);
      c = -1;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (mem_rd) begin
            c = cyc;
            return;
         end
      end
      check("wait_mem_rd_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      int c0, c1, c2, s_incr, s_valid, s_hs;
      logic [7:0] a0, a1;
      for (int i = 0; i < 256; i++) rom[i] = 16'($urandom);
      rom[0] = 16'hA5A5;

      // Basic fetch: mem_rd in the second cycle after release, 5 cycles per instruction.
      auto_mem = 1'b1; lat_max = 1; stray_pct = 0;
      do_reset(8'h00);
      @(negedge clk);
      check("idle_cycle_after_release", 32'(mem_rd), 32'd0);
      @(negedge clk);
      check("first_rd_cycle2", 32'(mem_rd), 32'd1);
      check("first_rd_addr", 32'(mem_addr), 32'h00);
      c0 = cyc;
      #2; s_incr = n_incr; s_valid = n_valid;
      wait_rd(c1, 20);
      #2;
      check("per_instr_cycles", 32'(c1 - c0), 32'd5);
      check("second_rd_addr", 32'(mem_addr), 32'h01);
      check("valid_cycles_per_instr", 32'(n_valid - s_valid), 32'd1);
      check("incr_pulses_per_instr", 32'(n_incr - s_incr), 32'd1);

      // Decoder stall: ready low for 10 cycles in HOLD.
      instr_ready = 1'b0;
      for (int i = 0; i < 20 && !instr_valid; i++) @(negedge clk);
      check("stall_valid_seen", 32'(instr_valid), 32'd1);
      #2; s_incr = n_incr;
      repeat (10) begin
         @(negedge clk);
         check("stall_no_incr", 32'(incr), 32'd0);
         check("stall_valid", 32'(instr_valid), 32'd1);
      end
      instr_ready = 1'b1;
      repeat (4) @(negedge clk);
      #2;
      check("stall_single_incr", 32'(n_incr - s_incr), 32'd1);

      // PC wrap-around.
      do_reset(8'hFE);
      wait_rd(c0, 10);
      check("wrap_addr_fe", 32'(mem_addr), 32'hFE);
      wait_rd(c1, 20);
      check("wrap_addr_ff", 32'(mem_addr), 32'hFF);
      wait_rd(c2, 20);
      check("wrap_addr_00", 32'(mem_addr), 32'h00);
      check("wrap_no_extra_cycles", 32'(c2 - c1), 32'd5);

      // Halt raised while waiting on memory.
      wait_rd(c0, 20);
      a0 = mem_addr;
      #2; s_incr = n_incr; s_hs = n_hs;
      @(negedge clk);
      halt = 1'b1;
      repeat (20) begin
         @(negedge clk);
         check("halt_no_rd", 32'(mem_rd), 32'd0);
      end
      #2;
      check("halt_delivered", 32'(n_hs - s_hs), 32'd1);
      check("halt_one_incr", 32'(n_incr - s_incr), 32'd1);
      halt = 1'b0;
      wait_rd(c1, 6);
      a1 = a0 + 8'd1;
      check("halt_resume_addr", 32'(mem_addr), 32'(a1));

      // Reset in WAIT, stale ack two cycles after release.
      auto_mem = 1'b0;
      @(negedge clk);
      reset = 1'b1; pc_load = 1'b1; pc_load_val = 8'h10;
      @(negedge clk);
      check("midrst_instr", 32'(instr), 32'd0);
      check("midrst_valid", 32'(instr_valid), 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0; pc_load = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("midrst_fresh_req", 32'(mem_rd), 32'd1);
      man_data = 16'hDEAD; man_ack = 1'b1;
      @(negedge clk);
      man_ack = 1'b0;
      repeat (4) begin
         check("late_ack_instr", 32'(instr), 32'd0);
         check("late_ack_valid", 32'(instr_valid), 32'd0);
         @(negedge clk);
      end
      man_data = rom[8'h10]; man_ack = 1'b1;
      @(negedge clk);
      man_ack = 1'b0;
      @(negedge clk);
      check("midrst_real_instr", 32'(instr), 32'(rom[8'h10]));
      auto_mem = 1'b1;

      // Randomized traffic: latency, ready, halt and stray acks.
      lat_max = 4; stray_pct = 20;
      do_reset(8'($urandom));
      #2; s_hs = n_hs;
      for (int i = 0; i < 1500; i++) begin
         @(posedge clk);
         #1;
         instr_ready = (int'($urandom_range(99, 0)) < 70);
         if (int'($urandom_range(99, 0)) < 4) halt = ~halt;
      end
      halt = 1'b0; instr_ready = 1'b1;
      repeat (20) @(negedge clk);
      #2;
      check("random_progress", 32'(n_hs - s_hs > 50), 32'd1);

`ifdef FETCH_TIMEOUT_EN
      // Ack never arrives: sticky error after 15 WAIT cycles.
      do_reset(8'h20);
      auto_mem = 1'b0;
      wait_rd(c0, 10);
      #2; s_incr = n_incr;
      repeat (15) begin
         @(negedge clk);
         check("to_err_low_in_wait", 32'(fetch_err), 32'd0);
      end
      @(negedge clk);
      check("to_err_set", 32'(fetch_err), 32'd1);
      repeat (10) begin
         @(negedge clk);
         check("to_idle_no_rd", 32'(mem_rd), 32'd0);
      end
      #2;
      check("to_no_incr", 32'(n_incr - s_incr), 32'd0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
